// File: rtl/layer_sequencer.sv
// layer_sequencer: time-multiplexes one combinational neuron across N_NEURONS neurons,
// feeding bias/weights from a local register file and streaming each result out.
module layer_sequencer #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_field,
  input  logic [31:0]      cfg_wdata,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  output logic [31:0]      nrn_b,
  output logic [31:0]      nrn_w1,
  output logic [31:0]      nrn_w2,
  output logic [31:0]      nrn_x1,
  output logic [31:0]      nrn_x2,
  input  logic [31:0]      nrn_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for an input sample; config writes allowed
  // DRIVE | operands for neuron idx on nrn_*, neuron output settling
  // EMIT  | result held on out_* until out_ready
  typedef enum logic [1:0] {IDLE, DRIVE, EMIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_sel;
  logic [31:0]      rf_b  [N_NEURONS];
  logic [31:0]      rf_w1 [N_NEURONS];
  logic [31:0]      rf_w2 [N_NEURONS];
  logic [31:0]      rd_b, rd_w1, rd_w2;
  logic             cfg_ok;

  assign busy   = (state != IDLE);
  assign cfg_ok = (state == IDLE) && (cfg_field != 2'd3) && (int'(cfg_idx) < N_NEURONS);
  // In IDLE the next pass starts at entry 0; in EMIT the next operands are idx+1.
  assign rd_sel = (state == IDLE) ? '0 : idx + IDX_W'(1);

  always_comb begin
    rd_b  = '0;
    rd_w1 = '0;
    rd_w2 = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (int'(rd_sel) == i) begin
        rd_b  = rf_b[i];
        rd_w1 = rf_w1[i];
        rd_w2 = rf_w2[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      nrn_b     <= '0;
      nrn_w1    <= '0;
      nrn_w2    <= '0;
      nrn_x1    <= '0;
      nrn_x2    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        rf_b[i]  <= '0;
        rf_w1[i] <= '0;
        rf_w2[i] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < N_NEURONS; i++) begin
        if (cfg_we && cfg_ok && int'(cfg_idx) == i) begin
          case (cfg_field)
            2'd0:    rf_b[i]  <= cfg_wdata;
            2'd1:    rf_w1[i] <= cfg_wdata;
            2'd2:    rf_w2[i] <= cfg_wdata;
            default: ;
          endcase
        end
      end

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            nrn_x1   <= in_x1;
            nrn_x2   <= in_x2;
            nrn_b    <= rd_b;
            nrn_w1   <= rd_w1;
            nrn_w2   <= rd_w2;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          out_data  <= nrn_out;
          out_idx   <= idx;
          out_last  <= (int'(idx) == N_NEURONS - 1);
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              idx    <= rd_sel;
              nrn_b  <= rd_b;
              nrn_w1 <= rd_w1;
              nrn_w2 <= rd_w2;
              state  <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: stub neuron (b + x1), directed steps plus randomized passes
// checked against an array model of the register file.
module tb_layer_sequencer;
  localparam int N  = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [1:0]    cfg_field;
  logic [31:0]   cfg_wdata;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_x1, in_x2;
  logic [31:0]   nrn_b, nrn_w1, nrn_w2, nrn_x1, nrn_x2, nrn_out;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  layer_sequencer #(.N_NEURONS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
    .nrn_b(nrn_b), .nrn_w1(nrn_w1), .nrn_w2(nrn_w2), .nrn_x1(nrn_x1), .nrn_x2(nrn_x2),
    .nrn_out(nrn_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  assign nrn_out = nrn_b + nrn_x1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mb [N];
  logic [31:0] mw1[N];
  logic [31:0] mw2[N];

  int          opt_stall_idx;
  int          opt_stall_len;
  bit          opt_bad_write;
  bit          opt_keep_valid;
  logic [31:0] opt_nx1, opt_nx2;
  bit          opt_cfg_same;
  logic [31:0] opt_cfg_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mb[i] = '0; mw1[i] = '0; mw2[i] = '0;
    end
  endtask

  task automatic clear_opts();
    opt_stall_idx = -1; opt_stall_len = 0; opt_bad_write = 0;
    opt_keep_valid = 0; opt_nx1 = '0; opt_nx2 = '0;
    opt_cfg_same = 0; opt_cfg_data = '0;
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [1:0] field, input logic [31:0] data);
    bit legal;
    legal = (field != 2'd3) && (int'(idx) < N);
    cfg_we = 1'b1; cfg_idx = idx; cfg_field = field; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, !legal);
    if (legal) begin
      if (field == 2'd0) mb[idx]  = data;
      if (field == 2'd1) mw1[idx] = data;
      if (field == 2'd2) mw2[idx] = data;
    end
    tick();
    chk("cfg_err_once", cfg_err, 0);
  endtask

  task automatic run_pass(input logic [31:0] x1, input logic [31:0] x2);
    logic [31:0] eb[N], ew1[N], ew2[N];
    int stall;
    for (int i = 0; i < N; i++) begin
      eb[i] = mb[i]; ew1[i] = mw1[i]; ew2[i] = mw2[i];
    end
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1; in_x1 = x1; in_x2 = x2;
    if (opt_cfg_same) begin
      cfg_we = 1'b1; cfg_idx = '0; cfg_field = 2'd0; cfg_wdata = opt_cfg_data;
    end
    tick();
    cfg_we = 1'b0;
    if (opt_cfg_same) mb[0] = opt_cfg_data;
    if (opt_keep_valid) begin
      in_x1 = opt_nx1; in_x2 = opt_nx2;
    end else begin
      in_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      chk("drv_valid", out_valid, 0);
      chk("drv_busy", busy, 1);
      chk("drv_in_ready", in_ready, 0);
      chk("drv_cfg_err", cfg_err, 0);
      chk("drv_b", nrn_b, eb[i]);
      chk("drv_w1", nrn_w1, ew1[i]);
      chk("drv_w2", nrn_w2, ew2[i]);
      chk("drv_x1", nrn_x1, x1);
      chk("drv_x2", nrn_x2, x2);
      out_ready = 1'b0;
      tick();
      stall = (i == opt_stall_idx) ? opt_stall_len : 0;
      for (int j = 0; j <= stall; j++) begin
        chk("emit_valid", out_valid, 1);
        chk("emit_data", out_data, eb[i] + x1);
        chk("emit_idx", out_idx, 32'(i));
        chk("emit_last", out_last, i == N - 1);
        chk("emit_b", nrn_b, eb[i]);
        chk("emit_w1", nrn_w1, ew1[i]);
        chk("emit_x1", nrn_x1, x1);
        chk("emit_cfg_err", cfg_err, opt_bad_write && i == opt_stall_idx && j == 1);
        if (j == stall) begin
          out_ready = 1'b1;
          tick();
          out_ready = 1'b0;
        end else begin
          if (opt_bad_write && j == 0) begin
            cfg_we = 1'b1; cfg_idx = 3'd1; cfg_field = 2'd0; cfg_wdata = 32'hDEAD_0000;
          end
          tick();
          cfg_we = 1'b0;
        end
      end
    end
    chk("end_in_ready", in_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_x1 = '0; in_x2 = '0; out_ready = 1'b0;
    clear_model();
    clear_opts();

    // Reset: everything low, including in_ready
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_nrn_b", nrn_b, 0);
      chk("rst_nrn_x1", nrn_x1, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Single pass with b[i] = i * 1.0 and distinct weights
    for (int i = 0; i < N; i++) begin
      cfg_write(3'(i), 2'd0, 32'(i) << 16);
      cfg_write(3'(i), 2'd1, 32'h0100_0000 + 32'(i));
      cfg_write(3'(i), 2'd2, 32'h0200_0000 + 32'(i));
    end
    run_pass(32'h0001_0000, 32'h0003_0000);

    // Backpressure on result 1 with an illegal write while busy
    opt_stall_idx = 1; opt_stall_len = 5; opt_bad_write = 1;
    run_pass(32'h0001_0000, 32'hFFFF_0000);
    clear_opts();

    // Illegal writes in IDLE
    cfg_write(3'd2, 2'd3, 32'h1234_5678);
    cfg_write(3'd5, 2'd0, 32'h1234_5678);

    // Write landing in the same cycle as the input accept
    opt_cfg_same = 1; opt_cfg_data = 32'h0007_0000;
    run_pass(32'h8000_0000, 32'h0000_0001);
    clear_opts();
    run_pass(32'h0001_0000, 32'h0);

    // Back-to-back samples with in_valid held
    opt_keep_valid = 1; opt_nx1 = 32'h0005_5555; opt_nx2 = 32'h0006_6666;
    run_pass(32'h0002_0000, 32'h0004_0000);
    clear_opts();
    run_pass(32'h0005_5555, 32'h0006_6666);

    // Randomized passes and config traffic
    for (int p = 0; p < 8; p++) begin
      for (int w = 0; w < 3; w++)
        cfg_write(3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), $urandom());
      clear_opts();
      opt_stall_idx = $urandom_range(0, N - 1);
      opt_stall_len = $urandom_range(0, 3);
      opt_bad_write = (opt_stall_len > 0) && ($urandom_range(0, 1) == 1);
      opt_cfg_same  = ($urandom_range(0, 1) == 1);
      opt_cfg_data  = $urandom();
      run_pass($urandom(), $urandom());
    end
    clear_opts();

    // Reset while EMIT holds neuron 2
    for (int i = 0; i < N; i++) cfg_write(3'(i), 2'd0, 32'h0010_0000);
    in_valid = 1'b1; in_x1 = 32'h0001_0000; in_x2 = '0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    out_ready = 1'b0;
    tick();
    chk("mid_valid", out_valid, 1);
    chk("mid_idx", out_idx, 2);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    clear_model();
    tick();
    chk("midrst_rel_in_ready", in_ready, 1);
    run_pass(32'h0001_0000, 32'h0002_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
